// File: rtl/clint_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clint_trap_ctrl_pkg
// Purpose : Shared constants and types for the machine-mode trap sequencer:
//           CSR addresses, mcause codes, mstatus bit positions and the
//           sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package clint_trap_ctrl_pkg;

    // Machine-mode CSR addresses (12-bit CSR address space)
    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;

    // mcause codes
    localparam int unsigned c_cause_ecall  = 11;
    localparam int unsigned c_cause_ebreak = 3;
    localparam logic [31:0] c_irq_cause    = 32'h8000_000B;

    // mstatus bit positions
    localparam int unsigned c_mstatus_mie  = 3;
    localparam int unsigned c_mstatus_mpie = 7;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_W_MEPC     = 3'd1,
        S_W_MSTATUS  = 3'd2,
        S_W_MCAUSE   = 3'd3,
        S_ASSERT     = 3'd4,
        S_R_MSTATUS  = 3'd5,
        S_RET_ASSERT = 3'd6
    } trap_state_e;

endpackage : clint_trap_ctrl_pkg
`default_nettype wire

// File: rtl/clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clint_trap_ctrl
// Purpose : Core-local trap sequencer. On ECALL, EBREAK, an accepted external
//           interrupt or MRET it stalls the pipeline, performs ordered
//           one-per-cycle CSR writes on the CSR file's second write port and
//           then issues a one-cycle redirect to mtvec (trap) or mepc (MRET).
// Ports   :
//   clk, rst                  core clock, synchronous active-high reset
//   inst_valid_i/inst_addr_i  valid instruction in execute and its PC
//   is_ecall_i/is_ebreak_i/is_mret_i  instruction class decode
//   jump_flag_i/jump_addr_i   execute-stage redirect (used as interrupt epc)
//   irq_i, global_int_en_i    level interrupt request, mstatus.MIE
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i  current CSR values
//   csr_we_o/csr_waddr_o/csr_wdata_o      registered CSR write port
//   hold_o                    pipeline stall (combinational)
//   int_assert_o/int_addr_o   one-cycle redirect pulse and target
// Revision: 1.0 - initial release
// ============================================================================
module clint_trap_ctrl
    import clint_trap_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] IRQ_CAUSE = 32'h8000_000B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              is_ecall_i,
    input  logic              is_ebreak_i,
    input  logic              is_mret_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              irq_i,
    input  logic              global_int_en_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              hold_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    trap_state_e r_state;
    trap_state_e w_next_state;

    logic [DATA_W-1:0] r_epc;
    logic [DATA_W-1:0] r_cause;

    logic              r_csr_we;
    logic [ADDR_W-1:0] r_csr_waddr;
    logic [DATA_W-1:0] r_csr_wdata;
    logic              r_int_assert;
    logic [ADDR_W-1:0] r_int_addr;

    logic              w_csr_we;
    logic [ADDR_W-1:0] w_csr_waddr;
    logic [DATA_W-1:0] w_csr_wdata;
    logic              w_int_assert;
    logic [ADDR_W-1:0] w_int_addr;

    logic              w_eval;
    logic              w_take_ecall;
    logic              w_take_ebreak;
    logic              w_take_mret;
    logic              w_take_irq;
    logic              w_trap_trigger;
    logic [DATA_W-1:0] w_trig_epc;
    logic [DATA_W-1:0] w_trig_cause;
    logic [DATA_W-1:0] w_mstatus_trap;
    logic [DATA_W-1:0] w_mstatus_mret;
    logic [ADDR_W-1:0] w_mtvec_base;

    // Triggers are only looked at in IDLE; priority ecall > ebreak > mret > irq.
    // A losing irq is simply not taken and remains pending on its level.
    assign w_eval         = (r_state == S_IDLE) & inst_valid_i;
    assign w_take_ecall   = w_eval & is_ecall_i;
    assign w_take_ebreak  = w_eval & is_ebreak_i & ~is_ecall_i;
    assign w_take_mret    = w_eval & is_mret_i & ~is_ecall_i & ~is_ebreak_i;
    assign w_take_irq     = w_eval & irq_i & global_int_en_i
                          & ~is_ecall_i & ~is_ebreak_i & ~is_mret_i;
    assign w_trap_trigger = w_take_ecall | w_take_ebreak | w_take_irq;

    // An interrupt resumes at the redirect target if execute was jumping,
    // since the interrupted instruction itself is not executed.
    assign w_trig_epc   = w_take_irq ? DATA_W'(jump_flag_i ? jump_addr_i : inst_addr_i)
                                     : DATA_W'(inst_addr_i);
    assign w_trig_cause = w_take_ecall  ? DATA_W'(c_cause_ecall)  :
                          w_take_ebreak ? DATA_W'(c_cause_ebreak) : IRQ_CAUSE;

    // Stall starts in the trigger cycle so the trapping instruction never retires.
    assign hold_o = (r_state != S_IDLE) | w_trap_trigger | w_take_mret;

    // mstatus images: trap entry stacks MIE into MPIE and clears MIE;
    // MRET restores MIE from MPIE and sets MPIE.
    always_comb begin
        w_mstatus_trap                 = csr_mstatus_i;
        w_mstatus_trap[c_mstatus_mpie] = csr_mstatus_i[c_mstatus_mie];
        w_mstatus_trap[c_mstatus_mie]  = 1'b0;
        w_mstatus_mret                 = csr_mstatus_i;
        w_mstatus_mret[c_mstatus_mie]  = csr_mstatus_i[c_mstatus_mpie];
        w_mstatus_mret[c_mstatus_mpie] = 1'b1;
    end

    // Direct mode only: the mode bits are dropped from the vector base.
    always_comb begin
        w_mtvec_base       = ADDR_W'(csr_mtvec_i);
        w_mtvec_base[1:0]  = 2'b00;
    end

    // State register, epc/cause latches and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_epc        <= '0;
            r_cause      <= '0;
            r_csr_we     <= 1'b0;
            r_csr_waddr  <= '0;
            r_csr_wdata  <= '0;
            r_int_assert <= 1'b0;
            r_int_addr   <= '0;
        end else begin
            r_state      <= w_next_state;
            if (w_trap_trigger) begin
                r_epc   <= w_trig_epc;
                r_cause <= w_trig_cause;
            end
            r_csr_we     <= w_csr_we;
            r_csr_waddr  <= w_csr_waddr;
            r_csr_wdata  <= w_csr_wdata;
            r_int_assert <= w_int_assert;
            r_int_addr   <= w_int_addr;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_trap_trigger)   w_next_state = S_W_MEPC;
                else if (w_take_mret) w_next_state = S_R_MSTATUS;
                else                  w_next_state = S_IDLE;
            end
            S_W_MEPC:     w_next_state = S_W_MSTATUS;
            S_W_MSTATUS:  w_next_state = S_W_MCAUSE;
            S_W_MCAUSE:   w_next_state = S_ASSERT;
            S_ASSERT:     w_next_state = S_IDLE;
            S_R_MSTATUS:  w_next_state = S_RET_ASSERT;
            S_RET_ASSERT: w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Output decode: computed for the state being entered so the registered
    // outputs line up with that state. The mepc write uses the trigger-cycle
    // epc directly because the latch is loaded on the same edge.
    always_comb begin
        w_csr_we     = 1'b0;
        w_csr_waddr  = '0;
        w_csr_wdata  = '0;
        w_int_assert = 1'b0;
        w_int_addr   = '0;
        case (w_next_state)
            S_W_MEPC: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = ADDR_W'(c_csr_mepc);
                w_csr_wdata = w_trig_epc;
            end
            S_W_MSTATUS: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = ADDR_W'(c_csr_mstatus);
                w_csr_wdata = w_mstatus_trap;
            end
            S_W_MCAUSE: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = ADDR_W'(c_csr_mcause);
                w_csr_wdata = r_cause;
            end
            S_ASSERT: begin
                w_int_assert = 1'b1;
                w_int_addr   = w_mtvec_base;
            end
            S_R_MSTATUS: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = ADDR_W'(c_csr_mstatus);
                w_csr_wdata = w_mstatus_mret;
            end
            S_RET_ASSERT: begin
                w_int_assert = 1'b1;
                w_int_addr   = ADDR_W'(csr_mepc_i);
            end
            default: ;
        endcase
    end

    assign csr_we_o     = r_csr_we;
    assign csr_waddr_o  = r_csr_waddr;
    assign csr_wdata_o  = r_csr_wdata;
    assign int_assert_o = r_int_assert;
    assign int_addr_o   = r_int_addr;

endmodule : clint_trap_ctrl
`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clint_trap_ctrl
// Purpose : Directed self-checking bench for clint_trap_ctrl. Each scenario
//           drives a trigger and compares the full output bundle
//           {we, waddr, wdata, hold, int_assert, int_addr} cycle by cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clint_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        is_ecall_i;
    logic        is_ebreak_i;
    logic        is_mret_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        irq_i;
    logic        global_int_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    int n_vec = 0;
    int n_err = 0;

    // {we, waddr, wdata, hold, int_assert, int_addr}
    logic [98:0] obs;
    assign obs = {csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o};

    always #5 clk = ~clk;

    clint_trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .inst_valid_i    (inst_valid_i),
        .inst_addr_i     (inst_addr_i),
        .is_ecall_i      (is_ecall_i),
        .is_ebreak_i     (is_ebreak_i),
        .is_mret_i       (is_mret_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .irq_i           (irq_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .csr_we_o        (csr_we_o),
        .csr_waddr_o     (csr_waddr_o),
        .csr_wdata_o     (csr_wdata_o),
        .hold_o          (hold_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid_i = 1'b0;
        is_ecall_i   = 1'b0;
        is_ebreak_i  = 1'b0;
        is_mret_i    = 1'b0;
        jump_flag_i  = 1'b0;
        irq_i        = 1'b0;
    endtask

    task automatic test_reset();
        logic [98:0] exp;
        rst = 1'b1;
        clear_inputs();
        inst_addr_i = 32'h0; jump_addr_i = 32'h0; global_int_en_i = 1'b0;
        csr_mtvec_i = 32'h101; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
        tick(); tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        rst = 1'b0;
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_ecall();
        logic [98:0] exp;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h101;
        inst_valid_i = 1'b1; inst_addr_i = 32'h80; is_ecall_i = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t0 got=%h exp=%h", obs, exp); end
        tick(); clear_inputs(); #1;
        exp = {1'b1, 32'h341, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t1_mepc got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t2_mstatus got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h342, 32'hB, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t3_mcause got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t4_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ecall_t5_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_ebreak();
        logic [98:0] exp;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h101;
        inst_valid_i = 1'b1; inst_addr_i = 32'hC0; is_ebreak_i = 1'b1;
        tick(); clear_inputs(); #1;
        exp = {1'b1, 32'h341, 32'hC0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ebreak_t1_mepc got=%h exp=%h", obs, exp); end
        tick(); tick();
        exp = {1'b1, 32'h342, 32'h3, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ebreak_t3_mcause got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ebreak_t4_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL ebreak_t5_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_irq_jump();
        logic [98:0] exp;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h101; global_int_en_i = 1'b1;
        inst_valid_i = 1'b1; inst_addr_i = 32'h90; irq_i = 1'b1;
        jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        #1;
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t0 got=%h exp=%h", obs, exp); end
        tick(); clear_inputs(); #1;
        exp = {1'b1, 32'h341, 32'h200, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t1_mepc got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t2_mstatus got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t3_mcause got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t4_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL irq_t5_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_irq_masked();
        logic [98:0] exp;
        global_int_en_i = 1'b0;
        inst_valid_i = 1'b1; inst_addr_i = 32'h90; irq_i = 1'b1;
        #1;
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL masked_t0 got=%h exp=%h", obs, exp); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = '0; n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL masked_t%0d got=%h exp=%h", i, obs, exp); end
        end
        clear_inputs();
    endtask

    // ECALL wins over a simultaneous irq; afterwards MIE=0 so the level irq
    // waits, MRET re-enables it and the next valid instruction takes it.
    task automatic test_ecall_irq_mret();
        logic [98:0] exp;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h101; global_int_en_i = 1'b1;
        inst_valid_i = 1'b1; inst_addr_i = 32'hA0; is_ecall_i = 1'b1; irq_i = 1'b1;
        tick(); inst_valid_i = 1'b0; is_ecall_i = 1'b0; #1;
        exp = {1'b1, 32'h341, 32'hA0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL race_t1_mepc got=%h exp=%h", obs, exp); end
        tick(); tick();
        exp = {1'b1, 32'h342, 32'hB, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL race_t3_mcause got=%h exp=%h", obs, exp); end
        tick(); tick();
        // CSR file now reflects the trap: MIE=0, MPIE=1, mepc=0x84 (handler set)
        global_int_en_i = 1'b0; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h84;
        inst_valid_i = 1'b1; inst_addr_i = 32'h1000; is_mret_i = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL mret_t0 got=%h exp=%h", obs, exp); end
        tick(); inst_valid_i = 1'b0; is_mret_i = 1'b0; #1;
        exp = {1'b1, 32'h300, 32'h88, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL mret_t1_mstatus got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h84}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL mret_t2_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL mret_t3_idle got=%h exp=%h", obs, exp); end
        // MIE restored: the still-high irq is taken on the next valid instruction
        global_int_en_i = 1'b1; csr_mstatus_i = 32'h88;
        inst_valid_i = 1'b1; inst_addr_i = 32'h84;
        #1;
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t0 got=%h exp=%h", obs, exp); end
        tick(); clear_inputs(); #1;
        exp = {1'b1, 32'h341, 32'h84, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t1_mepc got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t2_mstatus got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t3_mcause got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t4_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL retake_t5_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        logic [98:0] exp;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h101;
        inst_valid_i = 1'b1; inst_addr_i = 32'h80; is_ecall_i = 1'b1;
        tick(); clear_inputs(); #1;
        exp = {1'b1, 32'h341, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rstmid_t1_mepc got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rstmid_t2_mstatus got=%h exp=%h", obs, exp); end
        rst = 1'b1;
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rstmid_t3_cleared got=%h exp=%h", obs, exp); end
        rst = 1'b0;
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rstmid_t4_no_redirect got=%h exp=%h", obs, exp); end
        tick();
        exp = '0; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rstmid_t5_idle got=%h exp=%h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_ebreak();
        test_irq_jump();
        test_irq_masked();
        test_ecall_irq_mret();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_clint_trap_ctrl
`default_nettype wire
